raster_line_merger: RTL and testbench
=====================================

Name: raster_line_merger

Overview:
- Downstream of the raster cores' writeback stage.
- Drains the per-core AXI-stream scanline outputs strictly in core-id order (core 0 first).
- Packs pairs of 16-bit pixel words into 32-bit beats on a single AXI-stream master toward the framebuffer DMA.
- Checks each core's TLAST framing and flags protocol errors.

Parameters:
- N_CORES, 32, number of raster cores / scanlines per tile.
- PIX_PER_LINE, 400, pixels per core line; must be even and >= 2.
- CW, $clog2(N_CORES), core index width (derived).
- PW, $clog2(PIX_PER_LINE), pixel counter width (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: begin draining a tile; ignored unless idle.
- busy  out  1  high from the cycle after an accepted start until the final beat is accepted.
- s_valid  in  N_CORES  per-core pixel valid.
- s_data  in  N_CORES*16  per-core pixel; core i occupies [16*i+15:16*i].
- s_last  in  N_CORES  per-core end-of-line marker.
- s_ready  out  N_CORES  per-core ready; at most one bit high (one-hot to the selected core).
- m_valid  out  1  output beat valid.
- m_data  out  32  packed beat: [15:0] = even pixel, [31:16] = odd pixel.
- m_last  out  1  marks the final beat of the tile.
- m_ready  in  1  downstream ready.
- proto_err  out  1  sticky framing error.
- frame_done  out  1  one-cycle pulse when the final beat is accepted.

Behaviour:
- Reset values: all outputs 0; internal state IDLE; sel=0, pix=0, half=0, low-half register 0.
- Input handshake for core i: s_valid[i] && s_ready[i]. Output handshake: m_valid && m_ready.
- States:
  - IDLE: s_ready=0. On start, load sel=0, pix=0, half=0, clear proto_err, go to DRAIN.
  - DRAIN:
    - s_ready[sel] = (half==0) || !m_valid || m_ready. All other s_ready bits are 0.
    - Accepted pixel with half==0: store in low register, set half=1.
    - Accepted pixel with half==1: load m_data={pixel, low}, m_valid=1, half=0. Set m_last=1 only if sel==N_CORES-1 and pix==PIX_PER_LINE-1.
    - Each accepted pixel increments pix.
    - At pix==PIX_PER_LINE-1 accepted: pix=0 and sel=sel+1. If sel was N_CORES-1, go to FINISH instead.
  - FINISH: s_ready=0. Hold m_valid until the handshake, then m_valid=0, m_last=0, pulse frame_done, busy=0, go to IDLE.
- m_valid clears on handshake unless a new beat is loaded in the same cycle. Simultaneous consume and load is legal: one beat per cycle throughput on odd pixels.
- m_data and m_last are stable while m_valid && !m_ready.
- Latency: beat m_valid rises the cycle after the odd pixel is accepted.
- Framing check: proto_err is set on an accepted pixel when s_last != (pix==PIX_PER_LINE-1). It is sticky until the next accepted start or reset. Draining continues by count, never by s_last.
- start while busy: ignored, no effect.
- reset mid-transfer: everything returns to reset values the next cycle. Any partially packed pixel and pending beat are dropped; no m_last is emitted.
- A core stalling (s_valid=0) stalls the merger; no timeout and no skipping of cores.
- sel never wraps within a tile. pix wraps at PIX_PER_LINE-1 to 0.

Optional Feature:
- Macro MERGER_LINE_LAST_EN.
- Defined: m_last is asserted on the final beat of every core line (pix==PIX_PER_LINE-1 at pack time), giving one AXI packet per scanline. frame_done is still pulsed only after the last core.
- Undefined: m_last only on the final beat of the tile, as above.

Test Plan:
- N_CORES=4, PIX_PER_LINE=8. start, all cores valid continuously with pixel value {core[3:0], 12'(index)}, m_ready=1 -> 16 beats. Beat 0 = 0x0001_0000, beat 4 = 0x1001_1000, beat 15 = 0x3007_3006 with m_last=1. frame_done pulses once, proto_err=0.
- Same stimulus, m_ready toggling 1/0 every cycle -> identical beat sequence. m_data is stable during stalls. Only one s_ready bit is high at any time, and only core 0 is selected until its 8th pixel.
- Core 2 asserts s_last on its 5th pixel (index 4) -> proto_err=1 and stays high. All 16 beats are still produced. A subsequent start clears proto_err.
- reset asserted after beat 6 while core 1 is mid-line -> next cycle m_valid=0, s_ready=0, busy=0. A new start replays from core 0 pixel 0.
- start pulsed again while busy at beat 3 -> ignored; the sequence completes with exactly 16 beats.
- With MERGER_LINE_LAST_EN defined -> m_last=1 on beats 3, 7, 11, 15 only.

Source files
------------

// File: rtl/raster_line_merger.sv
// Drains per-core 16-bit scanline streams in core-id order and packs pixel pairs into 32-bit beats.
// Build option: define MERGER_LINE_LAST_EN to mark the last beat of every core line with m_last.
module raster_line_merger #(
    parameter int N_CORES      = 32,
    parameter int PIX_PER_LINE = 400,
    localparam int CW = (N_CORES > 1) ? $clog2(N_CORES) : 1,
    localparam int PW = (PIX_PER_LINE > 1) ? $clog2(PIX_PER_LINE) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    input  logic [N_CORES-1:0]    s_valid,
    input  logic [N_CORES*16-1:0] s_data,
    input  logic [N_CORES-1:0]    s_last,
    output logic [N_CORES-1:0]    s_ready,
    output logic                  m_valid,
    output logic [31:0]           m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  proto_err,
    output logic                  frame_done,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam logic [CW-1:0] SEL_LAST = CW'(N_CORES - 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(PIX_PER_LINE - 1);

    state_t        state;
    logic [CW-1:0] sel;
    logic [PW-1:0] pix;
    logic          half;
    logic [15:0]   low;

    logic          sel_ready;
    logic          in_fire;
    logic          m_fire;
    logic          pix_end;
    logic          sel_end;
    logic          beat_last;
    logic [15:0]   pix_in;

    // Valid/ready: a transfer happens on a rising clk edge where both valid and ready are high;
    // a stalled output beat (m_valid && !m_ready) keeps m_data/m_last unchanged.
    // An even pixel only needs the low register; an odd pixel also needs the beat slot free.
    assign sel_ready = !half || !m_valid || m_ready;
    assign pix_in    = s_data[16*int'(sel) +: 16];
    assign in_fire   = (state == ST_DRAIN) && s_valid[sel] && sel_ready;
    assign m_fire    = m_valid && m_ready;
    assign pix_end   = (pix == PIX_LAST);
    assign sel_end   = (sel == SEL_LAST);
    assign state_dbg = state;

`ifdef MERGER_LINE_LAST_EN
    assign beat_last = pix_end;
`else
    assign beat_last = pix_end && sel_end;
`endif

    always_comb begin
        s_ready = '0;
        if (state == ST_DRAIN) begin
            s_ready[sel] = sel_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            sel        <= '0;
            pix        <= '0;
            half       <= 1'b0;
            low        <= '0;
            busy       <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            proto_err  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sel       <= '0;
                        pix       <= '0;
                        half      <= 1'b0;
                        proto_err <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (m_fire) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                    end
                    if (in_fire) begin
                        if (s_last[sel] != pix_end) begin
                            proto_err <= 1'b1;
                        end
                        if (!half) begin
                            low  <= pix_in;
                            half <= 1'b1;
                        end else begin
                            m_data  <= {pix_in, low};
                            m_valid <= 1'b1;
                            m_last  <= beat_last;
                            half    <= 1'b0;
                        end
                        // Line length is counted; s_last only feeds the framing check.
                        if (pix_end) begin
                            pix <= '0;
                            if (sel_end) begin
                                state <= ST_FINISH;
                            end else begin
                                sel <= sel + CW'(1);
                            end
                        end else begin
                            pix <= pix + PW'(1);
                        end
                    end
                end
                ST_FINISH: begin
                    if (m_fire) begin
                        m_valid    <= 1'b0;
                        m_last     <= 1'b0;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_raster_line_merger.sv
// Scoreboarded bench for raster_line_merger: random valid/ready, line-level reference model.
module tb_raster_line_merger;

    localparam int N     = 4;
    localparam int P     = 8;
    localparam int BEATS = N * P / 2;
`ifdef MERGER_LINE_LAST_EN
    localparam bit LINE_LAST = 1'b1;
`else
    localparam bit LINE_LAST = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic           busy;
    logic [N-1:0]   s_valid = '0;
    logic [N*16-1:0] s_data = '0;
    logic [N-1:0]   s_last = '0;
    logic [N-1:0]   s_ready;
    logic           m_valid;
    logic [31:0]    m_data;
    logic           m_last;
    logic           m_ready = 1'b1;
    logic           proto_err;
    logic           frame_done;
    logic [1:0]     state_dbg;

    raster_line_merger #(.N_CORES(N), .PIX_PER_LINE(P)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .proto_err(proto_err), .frame_done(frame_done), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [15:0] line_mem[N][P];
    int          idx[N];
    logic [N-1:0] in_fire = '0;
    int          valid_pct = 100;
    int          ready_mode = 0;
    int          err_core = -1;
    int          err_idx = -1;
    int          beat_cnt = 0;
    int          frame_cnt = 0;
    logic        prev_hold = 1'b0;
    logic [32:0] prev_beat = '0;
    int          mon_cur;
    logic [N-1:0] mon_mask;
    logic [N-1:0] one_hot_base = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        in_fire = s_valid & s_ready;
        if (!reset) begin
            check("s_ready_onehot", 64'($onehot0(s_ready)), 64'd1);
            mon_cur = N;
            for (int c = N - 1; c >= 0; c--) begin
                if (idx[c] < P) mon_cur = c;
            end
            mon_mask = (mon_cur < N) ? (one_hot_base << mon_cur) : '0;
            check("s_ready_order", 64'(s_ready & ~mon_mask), 64'd0);
            if (prev_hold) begin
                check("stall_hold", {m_valid, m_last, m_data}, {1'b1, prev_beat});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got 0x%0h, expected no beat", m_data);
                end else begin
                    check("beat", {m_last, m_data}, exp_q.pop_front());
                end
                got_q.push_back(m_data);
                beat_cnt++;
            end
            if (frame_done) frame_cnt++;
            prev_hold = m_valid && !m_ready;
            prev_beat = {m_last, m_data};
        end else begin
            prev_hold = 1'b0;
        end
    end

    // source cores and downstream ready driver
    always @(posedge clk) begin
        #1;
        for (int c = 0; c < N; c++) begin
            if (in_fire[c] && idx[c] < P) idx[c]++;
        end
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        for (int c = 0; c < N; c++) begin
            if (idx[c] < P) begin
                s_valid[c] = ($urandom_range(1, 100) <= valid_pct);
                s_data[16*c +: 16] = line_mem[c][idx[c]];
                s_last[c] = (idx[c] == P - 1) || (c == err_core && idx[c] == err_idx);
            end else begin
                s_valid[c] = 1'b0;
                s_data[16*c +: 16] = 16'h0;
                s_last[c] = 1'b0;
            end
        end
    end

    // Reference: core lines in id order, pixel pairs packed low-first.
    task automatic setup_tile(input bit rnd);
        logic last;
        exp_q.delete();
        got_q.delete();
        beat_cnt  = 0;
        frame_cnt = 0;
        for (int c = 0; c < N; c++) begin
            idx[c] = 0;
            for (int i = 0; i < P; i++) begin
                line_mem[c][i] = rnd ? 16'($urandom) : {4'(c), 12'(i)};
            end
        end
        for (int c = 0; c < N; c++) begin
            for (int k = 0; k < P / 2; k++) begin
                last = (k == P / 2 - 1) && (LINE_LAST || c == N - 1);
                exp_q.push_back({last, line_mem[c][2*k+1], line_mem[c][2*k]});
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #2;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("proto_err_cleared", 64'(proto_err), 64'd0);
    endtask

    task automatic wait_frame(input int restart_at);
        int  cyc = 0;
        bit  restarted = 0;
        while (frame_cnt == 0 && cyc < 3000) begin
            @(posedge clk); #2;
            cyc++;
            start = 1'b0;
            if (restart_at >= 0 && !restarted && beat_cnt >= restart_at) begin
                start = 1'b1;
                restarted = 1;
            end
        end
        start = 1'b0;
        if (frame_cnt == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_timeout: got %0d beats, expected %0d", beat_cnt, BEATS);
        end
    endtask

    task automatic run_tile(input bit rnd, input int restart_at, input bit exp_err);
        setup_tile(rnd);
        pulse_start();
        wait_frame(restart_at);
        repeat (3) @(posedge clk);
        #2;
        check("frame_done_count", 64'(frame_cnt), 64'd1);
        check("beat_count", 64'(beat_cnt), 64'(BEATS));
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
        check("m_valid_idle", 64'(m_valid), 64'd0);
        check("proto_err", 64'(proto_err), 64'(exp_err));
    endtask

    task automatic reset_case();
        int cyc = 0;
        ready_mode = 0;
        valid_pct  = 100;
        setup_tile(1'b0);
        pulse_start();
        while (beat_cnt < 7 && cyc < 1000) begin
            @(posedge clk); #2;
            cyc++;
        end
        check("reset_point_beats", 64'(beat_cnt), 64'd7);
        reset = 1'b1;
        @(posedge clk); #2;
        for (int c = 0; c < N; c++) idx[c] = 0;
        exp_q.delete();
        check("rst_mid_m_valid", 64'(m_valid), 64'd0);
        check("rst_mid_m_last", 64'(m_last), 64'd0);
        check("rst_mid_s_ready", 64'(s_ready), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        for (int c = 0; c < N; c++) begin
            idx[c] = 0;
            for (int i = 0; i < P; i++) line_mem[c][i] = '0;
        end
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_proto_err", 64'(proto_err), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        reset = 1'b0;
        @(posedge clk); #2;

        // continuous flow, always ready
        run_tile(1'b0, -1, 1'b0);
        check("beat0_value", 64'(got_q[0]), 64'h0001_0000);
        check("beat4_value", 64'(got_q[4]), 64'h1001_1000);
        check("beat15_value", 64'(got_q[15]), 64'h3007_3006);

        // downstream toggling ready
        ready_mode = 1;
        run_tile(1'b0, -1, 1'b0);

        // early s_last on core 2 pixel 4
        ready_mode = 0;
        err_core = 2;
        err_idx  = 4;
        run_tile(1'b0, -1, 1'b1);
        err_core = -1;
        err_idx  = -1;
        run_tile(1'b0, -1, 1'b0);

        // reset mid-line, then replay from core 0
        reset_case();
        run_tile(1'b0, -1, 1'b0);
        check("replay_beat0", 64'(got_q[0]), 64'h0001_0000);

        // start while busy is ignored
        run_tile(1'b0, 3, 1'b0);

        // randomized data, valid and ready
        for (int t = 0; t < 6; t++) begin
            valid_pct  = $urandom_range(30, 100);
            ready_mode = 2;
            run_tile(1'b1, -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
